// File: rtl/hex_scroll_engine.sv
// Scrolling symbol register for the multi-digit 7-segment path: NUM_DIGITS x SYM_W, stepped per prescaler tick.
// Latency: Q, StepPulse and LapPulse are registered and visible the cycle after the tick edge.
// No backpressure: Run freezes the prescaler, and Clear (sync) dominates. Optional manual stepping uses HSS_MANUAL_STEP_EN.
module hex_scroll_engine #(
  parameter int NUM_DIGITS = 8,
  parameter int SYM_W      = 4,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic                        Clk,
  input  logic                        Resetn,
  input  logic                        Run,
  input  logic                        Clear,
  input  logic [1:0]                  Mode,
`ifdef HSS_MANUAL_STEP_EN
  input  logic                        StepReq,
`endif
  input  logic [SYM_W-1:0]            DataIn,
  output logic [NUM_DIGITS*SYM_W-1:0] Q,
  output logic                        StepPulse,
  output logic                        LapPulse
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW  = $clog2(NUM_DIGITS);
  localparam int TOP = NUM_DIGITS*SYM_W - 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LAP_MAX = LW'(NUM_DIGITS - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_ROTL  = 2'b10;
  localparam logic [1:0] MODE_ROTR  = 2'b11;

  logic [CW-1:0]  cnt;
  logic [LW-1:0]  lap;
  logic           prescale_tick;
  logic           tick;
  logic [TOP:0]   q_next;
  logic [LW-1:0]  lap_next;
  logic           lap_wrap;

  assign prescale_tick = Run && (cnt == CNT_MAX);

`ifdef HSS_MANUAL_STEP_EN
  // Two synchroniser flops plus a history flop; the rising edge is seen two edges after capture,
  // so the forced step lands on the third Clk edge after StepReq rises.
  logic [2:0] req_sync;
  logic       manual_tick;

  // StepReq synchroniser and edge history
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) req_sync <= '0;
    else         req_sync <= {req_sync[1:0], StepReq};
  end

  assign manual_tick = req_sync[1] & ~req_sync[2];
  assign tick        = prescale_tick | manual_tick;
`else
  assign tick = prescale_tick;
`endif

  // Next symbol vector and lap count for the step being taken this tick
  always_comb begin
    q_next   = Q;
    lap_next = '0;
    lap_wrap = 1'b0;
    case (Mode)
      MODE_HOLD:  q_next = Q;
      MODE_SHIFT: q_next = {Q[TOP-SYM_W:0], DataIn};
      MODE_ROTL:  q_next = {Q[TOP-SYM_W:0], Q[TOP -: SYM_W]};
      MODE_ROTR:  q_next = {Q[SYM_W-1:0], Q[TOP:SYM_W]};
      default:    q_next = Q;
    endcase
    // Only rotate steps advance the lap; hold and shift-in restart it.
    if (Mode[1]) begin
      if (lap == LAP_MAX) begin
        lap_next = '0;
        lap_wrap = 1'b1;
      end else begin
        lap_next = lap + LW'(1);
      end
    end
  end

  // Prescaler: counts while Run, restarts on any tick; Clear wins
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn)     cnt <= '0;
    else if (Clear)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else if (Run)    cnt <= cnt + CW'(1);
  end

  // Symbol register, lap counter and registered step/lap pulses
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Q         <= '0;
      lap       <= '0;
      StepPulse <= 1'b0;
      LapPulse  <= 1'b0;
    end else if (Clear) begin
      Q         <= '0;
      lap       <= '0;
      StepPulse <= 1'b0;
      LapPulse  <= 1'b0;
    end else if (tick) begin
      Q         <= q_next;
      lap       <= lap_next;
      StepPulse <= 1'b1;
      LapPulse  <= lap_wrap;
    end else begin
      StepPulse <= 1'b0;
      LapPulse  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_scroll_engine.sv
// Directed bench for hex_scroll_engine with NUM_DIGITS=4, SYM_W=4, TICK_DIV=4.
// Table of per-step vectors plus hand sequences for run/clear/reset corners.
// Manual-step sequence is included when HSS_MANUAL_STEP_EN is defined.
module tb_hex_scroll_engine;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b1;
  logic        Run = 1'b1;
  logic        Clear = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic [3:0]  DataIn = 4'h0;
  logic [15:0] Q;
  logic        StepPulse;
  logic        LapPulse;
`ifdef HSS_MANUAL_STEP_EN
  logic        StepReq = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hex_scroll_engine #(.NUM_DIGITS(4), .SYM_W(4), .TICK_DIV(4)) dut (
    .Clk(Clk), .Resetn(Resetn), .Run(Run), .Clear(Clear), .Mode(Mode),
`ifdef HSS_MANUAL_STEP_EN
    .StepReq(StepReq),
`endif
    .DataIn(DataIn), .Q(Q), .StepPulse(StepPulse), .LapPulse(LapPulse)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  din;
    logic [15:0] q;
    logic        lap;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for StepPulse, sampling 1 time unit after each rising edge.
  task automatic wait_step(output int cyc);
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
    end while (!StepPulse && cyc < 20);
    if (!StepPulse) check("step_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{2'b01, 4'h1, 16'h0001, 1'b0};
    vecs[1]  = '{2'b01, 4'h2, 16'h0012, 1'b0};
    vecs[2]  = '{2'b01, 4'h3, 16'h0123, 1'b0};
    vecs[3]  = '{2'b01, 4'h4, 16'h1234, 1'b0};
    vecs[4]  = '{2'b01, 4'h5, 16'h2345, 1'b0};
    vecs[5]  = '{2'b11, 4'h0, 16'h5234, 1'b0};
    vecs[6]  = '{2'b10, 4'h0, 16'h2345, 1'b0};
    vecs[7]  = '{2'b01, 4'h1, 16'h3451, 1'b0};
    vecs[8]  = '{2'b01, 4'h2, 16'h4512, 1'b0};
    vecs[9]  = '{2'b01, 4'h3, 16'h5123, 1'b0};
    vecs[10] = '{2'b01, 4'h4, 16'h1234, 1'b0};
    vecs[11] = '{2'b10, 4'h0, 16'h2341, 1'b0};
    vecs[12] = '{2'b10, 4'h0, 16'h3412, 1'b0};
    vecs[13] = '{2'b10, 4'h0, 16'h4123, 1'b0};
    vecs[14] = '{2'b10, 4'h0, 16'h1234, 1'b1};
    vecs[15] = '{2'b11, 4'h0, 16'h4123, 1'b0};
    vecs[16] = '{2'b00, 4'h0, 16'h4123, 1'b0};
    vecs[17] = '{2'b00, 4'h0, 16'h4123, 1'b0};
    vecs[18] = '{2'b00, 4'h0, 16'h4123, 1'b0};
    vecs[19] = '{2'b11, 4'h0, 16'h3412, 1'b0};
    vecs[20] = '{2'b11, 4'h0, 16'h2341, 1'b0};
    vecs[21] = '{2'b11, 4'h0, 16'h1234, 1'b0};
    vecs[22] = '{2'b11, 4'h0, 16'h4123, 1'b1};

    // Power-on reset
    #2 Resetn = 1'b0;
    #1;
    check("reset_q", Q, 16'h0000);
    check("reset_step", StepPulse, 1'b0);
    check("reset_lap", LapPulse, 1'b0);
    @(posedge Clk);
    @(posedge Clk);
    #1 Resetn = 1'b1;

    // Step table: shift-in, rotate, hold and lap behaviour
    for (int i = 0; i < 23; i++) begin
      Mode   = vecs[i].mode;
      DataIn = vecs[i].din;
      wait_step(cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), (i == 0) ? 32'd4 : 32'd3);
      check($sformatf("vec%0d_q", i), Q, vecs[i].q);
      check($sformatf("vec%0d_lap", i), LapPulse, vecs[i].lap);
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d_step_width", i), StepPulse, 1'b0);
      check($sformatf("vec%0d_lap_width", i), LapPulse, 1'b0);
    end

    // Run=0 freezes prescaler and Q
    Run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      check("frozen_step", StepPulse, 1'b0);
      check("frozen_q", Q, 16'h4123);
    end
    Run = 1'b1;
    wait_step(cyc);
    check("resume_cycles", 32'(cyc), 32'd3);
    check("resume_q", Q, 16'h3412);

    // Clear on the tick edge suppresses the step
    repeat (3) @(posedge Clk);
    #1 Clear = 1'b1;
    @(posedge Clk);
    #1;
    check("clear_q", Q, 16'h0000);
    check("clear_step", StepPulse, 1'b0);
    check("clear_lap", LapPulse, 1'b0);
    Clear = 1'b0;
    wait_step(cyc);
    check("post_clear_cycles", 32'(cyc), 32'd4);
    check("post_clear_q", Q, 16'h0000);

    // Reset while StepPulse is high, then restart timing
    Mode = 2'b01;
    DataIn = 4'hA;
    wait_step(cyc);
    check("pre_reset_q", Q, 16'h000A);
    Resetn = 1'b0;
    #1;
    check("midreset_q", Q, 16'h0000);
    check("midreset_step", StepPulse, 1'b0);
    #5 Resetn = 1'b1;
    wait_step(cyc);
    check("post_reset_cycles", 32'(cyc), 32'd4);
    check("post_reset_q", Q, 16'h000A);

    // Clear still applies with Run=0
    @(posedge Clk);
    #1;
    Run = 1'b0;
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    check("clear_norun_q", Q, 16'h0000);
    Clear = 1'b0;
    Run = 1'b1;

`ifdef HSS_MANUAL_STEP_EN
    // Load 1234, then force one rotate-left step with the prescaler stopped
    Mode = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      DataIn = 4'(i);
      wait_step(cyc);
    end
    check("manual_load_q", Q, 16'h1234);
    Run = 1'b0;
    Mode = 2'b10;
    StepReq = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("manual_early_q", Q, 16'h1234);
    check("manual_early_step", StepPulse, 1'b0);
    @(posedge Clk);
    #1;
    check("manual_q", Q, 16'h2341);
    check("manual_step", StepPulse, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      check("manual_held_q", Q, 16'h2341);
    end
    StepReq = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
